// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory port: load/store codes, arbiter FSM
// states, response owner tags and the bundled memory request.
package dmem_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned LOAD_W   = 3;
    localparam int unsigned STORE_W  = 2;
    localparam int unsigned STARVE_W = 4;

    // Load/store encodings are also decoded by the data memory.
    typedef enum logic [LOAD_W-1:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LH   = 3'd2,
        LOAD_LW   = 3'd3,
        LOAD_LBU  = 3'd4,
        LOAD_LHU  = 3'd5
    } load_op_t;

    typedef enum logic [STORE_W-1:0] {
        STORE_NONE = 2'd0,
        STORE_SB   = 2'd1,
        STORE_SH   = 2'd2,
        STORE_SW   = 2'd3
    } store_op_t;

    typedef enum logic {
        ARB      = 1'b0,
        EXT_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_EXT = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } resp_tag_t;

    typedef struct packed {
        logic [LOAD_W-1:0]  load;
        logic [STORE_W-1:0] store;
        logic [XLEN-1:0]    addr;
        logic [XLEN-1:0]    wdata;
    } mem_req_t;

    function automatic logic is_load(input logic [LOAD_W-1:0] code);
        return code != LOAD_NONE;
    endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Wait counter for the external master; raises force_ext once the master has
// been refused STARVE_LIMIT consecutive cycles.
module dmem_arb_starve
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
)(
    input  logic clk,
    input  logic rst,
    input  logic ext_req,
    input  logic ext_gnt,
    output logic force_ext
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] wait_count;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_count <= '0;
        end else if (!ext_req || ext_gnt) begin
            wait_count <= '0;
        end else if (wait_count != LIMIT) begin
            wait_count <= wait_count + STARVE_W'(1);
        end
    end

    assign force_ext = (wait_count == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the data-memory port (CPU primary, external master
// secondary) with tagged read-response steering. DMEM_ARB_STARVE_GUARD_EN
// enables the anti-starvation guard for the external master.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
)(
    input  logic               clk,
    input  logic               rst,

    input  logic               cpu_req,
    input  logic [LOAD_W-1:0]  cpu_load,
    input  logic [STORE_W-1:0] cpu_store,
    input  logic [XLEN-1:0]    cpu_addr,
    input  logic [XLEN-1:0]    cpu_wdata,
    output logic               cpu_stall,
    output logic               cpu_rvalid,
    output logic [XLEN-1:0]    cpu_rdata,

    input  logic               ext_req,
    input  logic [LOAD_W-1:0]  ext_load,
    input  logic [STORE_W-1:0] ext_store,
    input  logic [XLEN-1:0]    ext_addr,
    input  logic [XLEN-1:0]    ext_wdata,
    input  logic               ext_lock,
    output logic               ext_gnt,
    output logic               ext_rvalid,
    output logic [XLEN-1:0]    ext_rdata,

    output logic [LOAD_W-1:0]  mem_load,
    output logic [STORE_W-1:0] mem_store,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic [XLEN-1:0]    mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("dmem_arbiter: STARVE_LIMIT must lie in 1..15");
    end

    arb_state_t state;
    resp_tag_t  tag;
    logic       cpu_grant;
    logic       ext_grant;
    logic       starve_force;
    mem_req_t   cpu_bus;
    mem_req_t   ext_bus;
    mem_req_t   mem_bus;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    dmem_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .ext_req   (ext_req),
        .ext_gnt   (ext_gnt),
        .force_ext (starve_force)
    );
`else
    assign starve_force = 1'b0;
`endif

    assign cpu_bus = '{load: cpu_load, store: cpu_store, addr: cpu_addr, wdata: cpu_wdata};
    assign ext_bus = '{load: ext_load, store: ext_store, addr: ext_addr, wdata: ext_wdata};

    // A held lock wins outright; once it drops, the same cycle falls back to
    // normal CPU-first arbitration with the starvation override.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        cpu_grant = 1'b0;
        ext_grant = 1'b0;
        if (state == EXT_LOCK && ext_req && ext_lock) begin
            ext_grant = 1'b1;
        end else if (cpu_req && !(starve_force && ext_req)) begin
            cpu_grant = 1'b1;
        end else if (ext_req) begin
            ext_grant = 1'b1;
        end
    end

    always_comb begin
        mem_bus = '0;
        if (cpu_grant) begin
            mem_bus = cpu_bus;
        end else if (ext_grant) begin
            mem_bus = ext_bus;
        end
    end

    assign mem_load  = mem_bus.load;
    assign mem_store = mem_bus.store;
    assign mem_addr  = mem_bus.addr;
    assign mem_wdata = mem_bus.wdata;

    assign cpu_stall = cpu_req & ~cpu_grant;
    assign ext_gnt   = ext_req & ext_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            tag.valid <= 1'b0;
            tag.owner <= OWNER_CPU;
        end else begin
            state     <= (ext_gnt && ext_lock) ? EXT_LOCK : ARB;
            tag.valid <= (cpu_grant && is_load(cpu_load)) || (ext_grant && is_load(ext_load));
            tag.owner <= cpu_grant ? OWNER_CPU : OWNER_EXT;
        end
    end

    assign cpu_rvalid = tag.valid && (tag.owner == OWNER_CPU);
    assign ext_rvalid = tag.valid && (tag.owner == OWNER_EXT);
    assign cpu_rdata  = mem_rdata;
    assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-wide data memory model behind it.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_stall, cpu_rvalid;
    logic [2:0]  cpu_load;
    logic [1:0]  cpu_store;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_lock, ext_gnt, ext_rvalid;
    logic [2:0]  ext_load;
    logic [1:0]  ext_store;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic [2:0]  mem_load;
    logic [1:0]  mem_store;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_load   (cpu_load),
        .cpu_store  (cpu_store),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (ext_req),
        .ext_load   (ext_load),
        .ext_store  (ext_store),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_lock   (ext_lock),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Data memory: write commits at the edge, read data registered one cycle.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_store != STORE_NONE) mem[mem_addr[11:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[11:2]];
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(cpu_req && cpu_load != LOAD_NONE && cpu_store != STORE_NONE))
                else $error("illegal CPU request: load and store both set");
            assert (!(ext_req && ext_load != LOAD_NONE && ext_store != STORE_NONE))
                else $error("illegal external request: load and store both set");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cpu_drive(input logic req, input logic [2:0] ld, input logic [1:0] st,
                             input logic [31:0] addr, input logic [31:0] wd);
        cpu_req = req; cpu_load = ld; cpu_store = st; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic ext_drive(input logic req, input logic [2:0] ld, input logic [1:0] st,
                             input logic [31:0] addr, input logic [31:0] wd, input logic lock);
        ext_req = req; ext_load = ld; ext_store = st; ext_addr = addr; ext_wdata = wd; ext_lock = lock;
    endtask

    task automatic cpu_idle();
        cpu_drive(1'b0, LOAD_NONE, STORE_NONE, 32'h0, 32'h0);
    endtask

    task automatic ext_idle();
        ext_drive(1'b0, LOAD_NONE, STORE_NONE, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cpu_idle();
        ext_idle();
        tick();
        settle();
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("rst_ext_rvalid", 32'(ext_rvalid), 32'h0);
        check("rst_mem_store",  32'(mem_store),  32'h0);
        check("rst_ext_gnt",    32'(ext_gnt),    32'h0);
        rst = 1'b0;
        tick();

        // CPU store, store, load, then response.
        cpu_drive(1'b1, LOAD_NONE, STORE_SW, 32'h100, 32'hDEADBEEF); settle();
        check("sw_cpu_stall", 32'(cpu_stall), 32'h0);
        check("sw_mem_store", 32'(mem_store), 32'(STORE_SW));
        check("sw_mem_addr",  mem_addr,  32'h100);
        check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        cpu_drive(1'b1, LOAD_NONE, STORE_SW, 32'h200, 32'h12345678); settle();
        check("sw_no_rvalid", 32'(cpu_rvalid), 32'h0);
        tick();
        cpu_drive(1'b1, LOAD_LW, STORE_NONE, 32'h100, 32'h0); settle();
        check("lw_cpu_stall", 32'(cpu_stall), 32'h0);
        check("lw_mem_load",  32'(mem_load),  32'(LOAD_LW));
        check("lw_mem_store", 32'(mem_store), 32'h0);
        tick();
        cpu_idle(); settle();
        check("lw_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("lw_cpu_rdata",  cpu_rdata, 32'hDEADBEEF);
        check("lw_ext_rvalid", 32'(ext_rvalid), 32'h0);
        tick();

        // Contention: CPU wins while it requests, then external load goes.
        cpu_drive(1'b1, LOAD_LW, STORE_NONE, 32'h100, 32'h0);
        ext_drive(1'b1, LOAD_LW, STORE_NONE, 32'h200, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            check("pri_ext_gnt",   32'(ext_gnt),   32'h0);
            check("pri_cpu_stall", 32'(cpu_stall), 32'h0);
            check("pri_mem_addr",  mem_addr, 32'h100);
            tick();
        end
        cpu_idle(); settle();
        check("pri_ext_gnt_late", 32'(ext_gnt), 32'h1);
        check("pri_mem_addr_ext", mem_addr, 32'h200);
        check("pri_cpu_rvalid",   32'(cpu_rvalid), 32'h1);
        check("pri_cpu_rdata",    cpu_rdata, 32'hDEADBEEF);
        tick();
        ext_idle(); settle();
        check("pri_ext_rvalid", 32'(ext_rvalid), 32'h1);
        check("pri_ext_rdata",  ext_rdata, 32'h12345678);
        check("pri_cpu_rvalid_off", 32'(cpu_rvalid), 32'h0);
        tick();
        settle();
        check("pri_ext_rvalid_off", 32'(ext_rvalid), 32'h0);
        tick();

        // Continuous CPU traffic with the external master waiting.
        cpu_drive(1'b1, LOAD_LW, STORE_NONE, 32'h100, 32'h0);
        ext_drive(1'b1, LOAD_LW, STORE_NONE, 32'h200, 32'h0, 1'b0);
`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            settle();
            check("starve_ext_gnt",   32'(ext_gnt),   (i == 3) ? 32'h1 : 32'h0);
            check("starve_cpu_stall", 32'(cpu_stall), (i == 3) ? 32'h1 : 32'h0);
            tick();
        end
        ext_idle(); settle();
        check("starve_counter_clr", 32'(dut.u_starve.wait_count), 32'h0);
        check("starve_cpu_resume",  32'(cpu_stall), 32'h0);
        check("starve_ext_rvalid",  32'(ext_rvalid), 32'h1);
        check("starve_ext_rdata",   ext_rdata, 32'h12345678);
        tick();
`else
        for (int i = 0; i < 6; i++) begin
            settle();
            check("strict_ext_gnt",   32'(ext_gnt),   32'h0);
            check("strict_cpu_stall", 32'(cpu_stall), 32'h0);
            tick();
        end
        ext_idle();
`endif
        cpu_idle();
        tick();

        // Locked external burst: four stores and a load, CPU joins after beat 0.
        for (int i = 0; i < 5; i++) begin
            if (i == 0) cpu_idle();
            else        cpu_drive(1'b1, LOAD_LW, STORE_NONE, 32'h100, 32'h0);
            if (i < 4) ext_drive(1'b1, LOAD_NONE, STORE_SW, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1);
            else       ext_drive(1'b1, LOAD_LW, STORE_NONE, 32'h300, 32'h0, 1'b1);
            settle();
            check("lock_ext_gnt",   32'(ext_gnt),   32'h1);
            check("lock_cpu_stall", 32'(cpu_stall), (i > 0) ? 32'h1 : 32'h0);
            check("lock_mem_addr",  mem_addr, (i < 4) ? 32'h300 + 32'(4 * i) : 32'h300);
            tick();
        end
        ext_drive(1'b1, LOAD_LW, STORE_NONE, 32'h304, 32'h0, 1'b0); settle();
        check("unlock_ext_gnt",    32'(ext_gnt),   32'h0);
        check("unlock_cpu_stall",  32'(cpu_stall), 32'h0);
        check("unlock_mem_addr",   mem_addr, 32'h100);
        check("unlock_ext_rvalid", 32'(ext_rvalid), 32'h1);
        check("unlock_ext_rdata",  ext_rdata, 32'hA0);
        tick();
        cpu_idle(); settle();
        check("unlock_ext_gnt2",   32'(ext_gnt), 32'h1);
        check("unlock_cpu_rdata",  cpu_rdata, 32'hDEADBEEF);
        tick();
        ext_idle(); settle();
        check("unlock_ext_rdata2", ext_rdata, 32'hA1);
        tick();

        // Reset drops a pending CPU response.
        cpu_drive(1'b1, LOAD_LW, STORE_NONE, 32'h100, 32'h0); settle();
        check("rstmid_cpu_stall", 32'(cpu_stall), 32'h0);
        tick();
        rst = 1'b1;
        cpu_idle(); settle();
        check("rstmid_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        tick();
        check("rstmid_cpu_rvalid2", 32'(cpu_rvalid), 32'h0);
        rst = 1'b0;
        cpu_drive(1'b1, LOAD_LW, STORE_NONE, 32'h100, 32'h0); settle();
        check("rstmid_regrant", 32'(cpu_stall), 32'h0);
        tick();
        cpu_idle(); settle();
        check("rstmid_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();

        // Reset releases a held lock.
        ext_drive(1'b1, LOAD_NONE, STORE_SW, 32'h500, 32'h77, 1'b1); settle();
        check("rstlock_ext_gnt", 32'(ext_gnt), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_drive(1'b1, LOAD_LW, STORE_NONE, 32'h100, 32'h0); settle();
        check("rstlock_cpu_stall", 32'(cpu_stall), 32'h0);
        check("rstlock_ext_gnt2",  32'(ext_gnt),   32'h0);
        tick();
        cpu_idle(); ext_idle();

        // Idle cycles issue nothing to memory.
        for (int i = 0; i < 3; i++) begin
            settle();
            check("idle_mem_store", 32'(mem_store), 32'h0);
            check("idle_mem_load",  32'(mem_load),  32'h0);
            check("idle_mem_addr",  mem_addr, 32'h0);
            tick();
        end

        // CPU store and external load to the same address collide.
        cpu_drive(1'b1, LOAD_NONE, STORE_SW, 32'h400, 32'h55);
        ext_drive(1'b1, LOAD_LW, STORE_NONE, 32'h400, 32'h0, 1'b0); settle();
        check("coll_ext_gnt",   32'(ext_gnt),   32'h0);
        check("coll_mem_store", 32'(mem_store), 32'(STORE_SW));
        tick();
        cpu_idle(); settle();
        check("coll_ext_retry", 32'(ext_gnt), 32'h1);
        tick();
        ext_idle(); settle();
        check("coll_ext_rdata", ext_rdata, 32'h55);
        tick();

        // Back-to-back loads from alternating owners; contents survived idling.
        cpu_drive(1'b1, LOAD_LW, STORE_NONE, 32'h300, 32'h0); settle();
        tick();
        cpu_idle();
        ext_drive(1'b1, LOAD_LW, STORE_NONE, 32'h30C, 32'h0, 1'b0); settle();
        check("alt_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("alt_cpu_rdata",  cpu_rdata, 32'hA0);
        tick();
        ext_idle(); settle();
        check("alt_ext_rvalid", 32'(ext_rvalid), 32'h1);
        check("alt_cpu_rvalid2", 32'(cpu_rvalid), 32'h0);
        check("alt_ext_rdata",  ext_rdata, 32'hA3);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between two requesters: the CPU load/store stage (primary) and an external master (program loader / debug port, secondary). Each cycle it chooses one requester, drives the memory's load/store/address/write-data inputs, stalls whichever requester loses, and steers the memory's registered read data back to the requester that issued the load. It sits between the execute stage and the data memory. An optional anti-starvation guard bounds the external master's wait.

## Interface
- STARVE_LIMIT, 8: external-master wait cycles that force an external grant (guard builds only); range 1..15
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access this cycle
- cpu_load  in  3  load code (shared encoding, 0 = none)
- cpu_store  in  2  store code (0 = none, Sb/Sh/Sw)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_stall  out  1  CPU request not granted this cycle
- cpu_rvalid  out  1  cpu_rdata holds the CPU's load result
- cpu_rdata  out  32  load data
- ext_req, ext_load[3], ext_store[2], ext_addr[32], ext_wdata[32]  in  external request; same meaning as the CPU fields
- ext_lock  in  1  keep the port for back-to-back external beats
- ext_gnt  out  1  external request accepted this cycle
- ext_rvalid  out  1, ext_rdata  out  32  external load response
- mem_load  out  3, mem_store  out  2, mem_addr  out  32, mem_wdata  out  32  to data memory
- mem_rdata  in  32  memory read data; registered, valid 1 cycle after issue

## Operation
- FSM states: ARB (default) and EXT_LOCK.
- In ARB, the CPU wins if cpu_req=1, unless the starvation force is active. Otherwise the external master wins if ext_req=1. Otherwise there is no grant.
- ARB to EXT_LOCK: at an edge where ext_gnt=1 and ext_lock=1.
- In EXT_LOCK, the external master has absolute priority and the CPU is stalled.
- EXT_LOCK to ARB: at the first cycle with ext_req=0 or ext_lock=0. That cycle arbitrates as in ARB.
- Granted requester's fields drive the mem_* outputs.
- With no grant: mem_load=0, mem_store=0, mem_addr=0, mem_wdata=0. No spurious writes.
- cpu_stall = cpu_req & ~cpu_grant. ext_gnt = ext_req & ext_grant.
- The external master holds its fields stable until ext_gnt.
- Response tag register: {valid, owner}. It is set at an edge when a granted access has a nonzero load code, and cleared otherwise.
- cpu_rvalid = tag.valid & owner==CPU. ext_rvalid likewise for the external master.
- cpu_rdata and ext_rdata both carry mem_rdata.
- Stores generate no response.
- A request with both load and store nonzero is illegal; the bench flags it with an assertion.

## Timing
- Grant, stall and mem_* are combinational within the request cycle.
- Memory write commits at the edge closing the grant cycle.
- Read latency is 1 cycle: rvalid and rdata are valid in the cycle after grant.
- Back-to-back loads from alternating owners give one response per cycle, each correctly tagged.
- Reset values: state=ARB, tag.valid=0, starvation counter=0, cpu_rvalid=0, ext_rvalid=0. Combinational outputs follow their inputs.
- Reset asserted mid-operation drops any pending response; no rvalid follows. A lock is released.
- Simultaneous CPU store and external load to the same address: only one is granted. The loser retries and sees the committed store.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - 4-bit wait counter increments each cycle ext_req & ~ext_gnt, saturating at STARVE_LIMIT.
  - Cleared on ext_gnt or ext_req=0.
  - While the counter equals STARVE_LIMIT in ARB, the external master wins over the CPU for one grant.
- Undefined: no counter, strict CPU priority in ARB. The external master can starve under continuous CPU traffic.

## Structure
- Load/store code constants (none, Lb…Lw, Sb/Sh/Sw), FSM state encodings and owner encodings go in the shared define header, used alongside the data memory.
- One sub-module: dmem_arb_starve, the wait counter and force flag. It is instantiated only under DMEM_ARB_STARVE_GUARD_EN.

## Test plan
- CPU Sw 0xDEADBEEF @0x100, then CPU Lw @0x100 -> cpu_stall=0 both cycles; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, ext_rvalid=0.
- cpu_req and ext_req (Lw @0x200) together, guard off -> CPU granted; ext_gnt=0 until the cycle cpu_req drops; ext_rvalid exactly 1 cycle later.
- Guard on, STARVE_LIMIT=3, CPU requesting continuously with ext_req held -> ext_gnt=1 on the 4th cycle, cpu_stall=1 that cycle only, counter back to 0.
- ext_lock=1 for 4 Sw beats @0x300..0x30C while CPU requests -> cpu_stall=1 for 4 cycles; the CPU is granted on the cycle ext_lock drops.
- rst pulsed the cycle after a granted CPU Lw -> cpu_rvalid stays 0; after release, state ARB and the next CPU request is granted at once.
- Idle cycles (no req) -> mem_store=0 and mem_load=0; memory contents unchanged.
